// File: rtl/dbus_cbus_bridge.sv
// dbus_cbus_bridge: turns one outstanding data-side pipeline request into a
// single-beat cache-bus transaction and returns data_ok with the read data.
// Stores are normalised to an 8-byte aligned MSIZE8 beat. Also provides a
// sticky watchdog flag and a wrapping completed-transaction counter.
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   dreq_valid/addr/size/strobe/data pipeline request (held until data_ok)
//   dresp_addr_ok/data_ok/data       pipeline response (addr_ok is combinational)
//   creq_valid/is_write/size/addr/strobe/data/len/burst  cache-bus request
//   cresp_ready/last/data            cache-bus response
//   err_timeout                      sticky watchdog flag
//   txn_count                        completed transactions, wraps at 2^32
module dbus_cbus_bridge #(
  parameter int unsigned WDOG_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        creq_valid,
  output logic        creq_is_write,
  output logic [2:0]  creq_size,
  output logic [63:0] creq_addr,
  output logic [7:0]  creq_strobe,
  output logic [63:0] creq_data,
  output logic [3:0]  creq_len,
  output logic [1:0]  creq_burst,
  input  logic        cresp_ready,
  input  logic        cresp_last,
  input  logic [63:0] cresp_data,
  output logic        err_timeout,
  output logic [31:0] txn_count
);

  localparam logic [2:0] MSIZE8          = 3'd3;
  localparam logic [3:0] MLEN1           = 4'd0;
  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam int unsigned WDOG_W = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [63:0]       addr_q, wdata_q, rdata_q;
  logic [2:0]        size_q;
  logic [7:0]        strobe_q;
  logic [WDOG_W-1:0] wdog_q;
  logic [WDOG_W-1:0] wdog_inc;
  logic              err_q;
  logic [31:0]       txn_q;
  logic              accept;
  logic              beat_done;
  logic              busy;
  logic              is_write;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, request acceptance and beat completion
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    beat_done = 1'b0;
    case (state_q)
      IDLE: if (dreq_valid) begin
        accept  = 1'b1;
        state_d = BUSY;
      end
      // a ready beat without last is a protocol violation for len=1; ignore it
      BUSY: if (cresp_ready && cresp_last) begin
        beat_done = 1'b1;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latches and captured response data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= dreq_addr;
        wdata_q  <= dreq_data;
        size_q   <= dreq_size;
        strobe_q <= dreq_strobe;
      end
      if (beat_done) rdata_q <= cresp_data;
    end
  end

  assign wdog_inc = wdog_q + WDOG_W'(1);

  // Watchdog: counts BUSY cycles, saturates; with WDOG_CYCLES=0 WDOG_MAX is 0 so it never moves
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      wdog_q <= '0;
    end else if (state_q == BUSY && wdog_q != WDOG_MAX) begin
      wdog_q <= wdog_inc;
      if (wdog_inc == WDOG_MAX) err_q <= 1'b1;
    end
  end

  // Completed-transaction counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                txn_q <= '0;
    else if (state_q == DONE) txn_q <= txn_q + 32'd1;
  end

  assign busy     = (state_q == BUSY);
  assign is_write = (strobe_q != 8'd0);

  // Cache-bus request: all-zero outside BUSY, constant during it
  assign creq_valid    = busy;
  assign creq_is_write = busy & is_write;
  assign creq_size     = !busy ? 3'd0 : (is_write ? MSIZE8 : size_q);
  assign creq_addr     = !busy ? 64'd0 : (is_write ? {addr_q[63:3], 3'b000} : addr_q);
  assign creq_strobe   = (busy && is_write) ? strobe_q : 8'd0;
  assign creq_data     = (busy && is_write) ? wdata_q : 64'd0;
  assign creq_len      = MLEN1;
  assign creq_burst    = AXI_BURST_FIXED;

  // Pipeline response
  assign dresp_addr_ok = (state_q == IDLE) && dreq_valid;
  assign dresp_data_ok = (state_q == DONE);
  assign dresp_data    = (state_q == DONE) ? rdata_q : 64'd0;

  assign err_timeout = err_q;
  assign txn_count   = txn_q;

endmodule

// File: tb/tb_dbus_cbus_bridge.sv
module tb_dbus_cbus_bridge;

  localparam int unsigned WDOG = 8;

  logic        clk;
  logic        reset;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        creq_valid;
  logic        creq_is_write;
  logic [2:0]  creq_size;
  logic [63:0] creq_addr;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic [3:0]  creq_len;
  logic [1:0]  creq_burst;
  logic        cresp_ready;
  logic        cresp_last;
  logic [63:0] cresp_data;
  logic        err_timeout;
  logic [31:0] txn_count;

  int n_pass;
  int n_total;
  int addr_ok_seen;
  // reference model state
  int unsigned cnt_m;
  bit          err_m;

  dbus_cbus_bridge #(.WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
    .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data),
    .creq_len(creq_len), .creq_burst(creq_burst),
    .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data),
    .err_timeout(err_timeout), .txn_count(txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction. Entered inside an IDLE cycle (before the edge);
  // returns inside the following IDLE cycle. lat = BUSY cycles before the beat.
  task automatic run_txn(input logic [63:0] addr, input logic [2:0] size,
                         input logic [7:0] strobe, input logic [63:0] wdata,
                         input int lat, input bit stray, input logic [63:0] rdata);
    bit          wr;
    logic [63:0] exp_addr;
    logic [2:0]  exp_size;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdat;
    bit          exp_err;
    wr       = (strobe != 8'd0);
    exp_addr = wr ? (addr & ~64'h7) : addr;
    exp_size = wr ? 3'd3 : size;
    exp_strb = wr ? strobe : 8'd0;
    exp_wdat = wr ? wdata : 64'd0;

    dreq_valid = 1'b1; dreq_addr = addr; dreq_size = size;
    dreq_strobe = strobe; dreq_data = wdata;
    #1;
    if (dresp_addr_ok) addr_ok_seen++;
    n_total++;
    if (dresp_addr_ok !== 1'b1) $display("FAIL accept_addr_ok got %0b exp 1", dresp_addr_ok); else n_pass++;
    n_total++;
    if (creq_valid !== 1'b0) $display("FAIL idle_creq_valid got %0b exp 0", creq_valid); else n_pass++;

    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk); #1;
      if (k == lat + 1) begin
        cresp_ready = 1'b1; cresp_last = 1'b1; cresp_data = rdata;
      end else if (stray && (k % 2 == 1)) begin
        cresp_ready = 1'b1; cresp_last = 1'b0; cresp_data = {$urandom, $urandom};
      end else begin
        cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = 64'd0;
      end
      #1;
      if (dresp_addr_ok) addr_ok_seen++;
      exp_err = err_m || ((k - 1) >= int'(WDOG));
      n_total++;
      if (creq_valid !== 1'b1 || creq_is_write !== wr || creq_addr !== exp_addr ||
          creq_size !== exp_size || creq_strobe !== exp_strb || creq_data !== exp_wdat ||
          creq_len !== 4'd0 || creq_burst !== 2'd0)
        $display("FAIL busy_creq cyc %0d got v%0b w%0b a%h s%0d st%h d%h l%0d b%0d exp v1 w%0b a%h s%0d st%h d%h l0 b0",
                 k, creq_valid, creq_is_write, creq_addr, creq_size, creq_strobe, creq_data,
                 creq_len, creq_burst, wr, exp_addr, exp_size, exp_strb, exp_wdat);
      else n_pass++;
      n_total++;
      if (dresp_addr_ok !== 1'b0 || dresp_data_ok !== 1'b0 || dresp_data !== 64'd0)
        $display("FAIL busy_dresp cyc %0d got aok%0b dok%0b d%h exp 0 0 0",
                 k, dresp_addr_ok, dresp_data_ok, dresp_data);
      else n_pass++;
      n_total++;
      if (err_timeout !== exp_err) $display("FAIL busy_err cyc %0d got %0b exp %0b", k, err_timeout, exp_err); else n_pass++;
    end

    @(posedge clk); #1;
    cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = 64'd0;
    #1;
    if (dresp_addr_ok) addr_ok_seen++;
    if (lat + 1 >= int'(WDOG)) err_m = 1'b1;
    n_total++;
    if (dresp_data_ok !== 1'b1 || dresp_data !== rdata)
      $display("FAIL done_data got ok%0b %h exp ok1 %h", dresp_data_ok, dresp_data, rdata);
    else n_pass++;
    n_total++;
    if (creq_valid !== 1'b0 || dresp_addr_ok !== 1'b0)
      $display("FAIL done_quiet got creq_valid %0b addr_ok %0b exp 0 0", creq_valid, dresp_addr_ok);
    else n_pass++;
    n_total++;
    if (txn_count !== cnt_m || err_timeout !== err_m)
      $display("FAIL done_count got %0d err %0b exp %0d err %0b", txn_count, err_timeout, cnt_m, err_m);
    else n_pass++;
    cnt_m++;

    @(posedge clk); #1;
    dreq_valid = 1'b0;
    #1;
    n_total++;
    if (dresp_data_ok !== 1'b0 || dresp_data !== 64'd0 || txn_count !== cnt_m || err_timeout !== err_m)
      $display("FAIL after_txn got dok%0b d%h cnt%0d err%0b exp dok0 d0 cnt%0d err%0b",
               dresp_data_ok, dresp_data, txn_count, err_timeout, cnt_m, err_m);
    else n_pass++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dreq_valid = 1'b0; cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = 64'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cnt_m = 0; err_m = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dreq_valid = 1'b1; dreq_addr = 64'h8000_0000; dreq_size = 3'd3;
    dreq_strobe = 8'hFF; dreq_data = 64'hDEAD;
    cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (creq_valid !== 1'b0 || creq_addr !== 64'd0 || creq_strobe !== 8'd0 || creq_data !== 64'd0 ||
        creq_size !== 3'd0 || creq_is_write !== 1'b0)
      $display("FAIL reset_creq got v%0b a%h st%h d%h s%0d w%0b exp all 0",
               creq_valid, creq_addr, creq_strobe, creq_data, creq_size, creq_is_write);
    else n_pass++;
    n_total++;
    if (dresp_data_ok !== 1'b0 || dresp_data !== 64'd0 || err_timeout !== 1'b0 || txn_count !== 32'd0)
      $display("FAIL reset_outputs got dok%0b d%h err%0b cnt%0d exp 0 0 0 0",
               dresp_data_ok, dresp_data, err_timeout, txn_count);
    else n_pass++;
    dreq_valid = 1'b0;
    reset = 1'b0;
    cnt_m = 0; err_m = 1'b0;
    #1;
    n_total++;
    if (dresp_addr_ok !== 1'b0) $display("FAIL reset_idle_addr_ok got %0b exp 0", dresp_addr_ok); else n_pass++;
  endtask

  task automatic test_load();
    run_txn(64'h8000_0013, 3'd1, 8'h00, 64'h0, 2, 1'b0, 64'h1122_3344_5566_7788);
    n_total++;
    if (txn_count !== 32'd1) $display("FAIL load_count got %0d exp 1", txn_count); else n_pass++;
  endtask

  task automatic test_store();
    run_txn(64'h8000_0016, 3'd0, 8'h40, 64'h00AB_0000_0000_0000, 1, 1'b0, 64'h0);
  endtask

  task automatic test_back_to_back();
    int start_cnt;
    int t0;
    start_cnt = addr_ok_seen;
    t0 = int'($time);
    run_txn(64'h8000_1000, 3'd2, 8'h00, 64'h0, 0, 1'b0, 64'hA5A5_0000_1111_2222);
    n_total++;
    if (int'($time) - t0 != 30) $display("FAIL b2b_latency got %0d exp 30", int'($time) - t0); else n_pass++;
    run_txn(64'h8000_1008, 3'd3, 8'h00, 64'h0, 0, 1'b0, 64'h5A5A_3333_4444_5555);
    n_total++;
    if (addr_ok_seen - start_cnt != 2) $display("FAIL b2b_addr_ok got %0d exp 2", addr_ok_seen - start_cnt); else n_pass++;
  endtask

  task automatic test_stray();
    run_txn(64'h8000_2004, 3'd2, 8'h00, 64'h0, 3, 1'b1, 64'hCAFE_F00D_0BAD_BEEF);
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [7:0]  s;
    for (int i = 0; i < 20; i++) begin
      a = {$urandom, $urandom};
      s = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'd0;
      run_txn(a, 3'($urandom_range(0, 3)), s, {$urandom, $urandom},
              int'($urandom_range(0, 4)), 1'($urandom), {$urandom, $urandom});
    end
  endtask

  task automatic test_watchdog();
    run_txn(64'h8000_3000, 3'd3, 8'h00, 64'h0, 12, 1'b0, 64'h0123_4567_89AB_CDEF);
    n_total++;
    if (err_timeout !== 1'b1) $display("FAIL wdog_sticky got %0b exp 1", err_timeout); else n_pass++;
    run_txn(64'h8000_3008, 3'd3, 8'h00, 64'h0, 0, 1'b0, 64'h1);
    do_reset();
    // beat coincides with the cycle the watchdog saturates
    run_txn(64'h8000_3010, 3'd3, 8'h00, 64'h0, int'(WDOG) - 1, 1'b0, 64'h2);
    n_total++;
    if (err_timeout !== 1'b1) $display("FAIL wdog_coincident got %0b exp 1", err_timeout); else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    bit saw_ok;
    dreq_valid = 1'b1; dreq_addr = 64'h8000_4000; dreq_size = 3'd3;
    dreq_strobe = 8'h00; dreq_data = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (creq_valid !== 1'b1) $display("FAIL midreset_pre got %0b exp 1", creq_valid); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (creq_valid !== 1'b0 || dresp_data_ok !== 1'b0 || err_timeout !== 1'b0 || txn_count !== 32'd0)
      $display("FAIL midreset_async got v%0b dok%0b err%0b cnt%0d exp 0 0 0 0",
               creq_valid, dresp_data_ok, err_timeout, txn_count);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0; dreq_valid = 1'b0;
    cnt_m = 0; err_m = 1'b0;
    saw_ok = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (dresp_data_ok || creq_valid) saw_ok = 1'b1;
    end
    n_total++;
    if (saw_ok !== 1'b0) $display("FAIL midreset_abandon got %0b exp 0", saw_ok); else n_pass++;
    run_txn(64'h8000_4010, 3'd2, 8'h00, 64'h0, 1, 1'b0, 64'h7777_6666_5555_4444);
    n_total++;
    if (txn_count !== 32'd1) $display("FAIL midreset_follow_count got %0d exp 1", txn_count); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0; addr_ok_seen = 0;
    cnt_m = 0; err_m = 1'b0;
    reset = 1'b1;
    dreq_valid = 1'b0; dreq_addr = 64'd0; dreq_size = 3'd0;
    dreq_strobe = 8'd0; dreq_data = 64'd0;
    cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = 64'd0;
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_stray();
    test_random();
    test_watchdog();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
